// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns single-cycle CPU data-port loads/stores into one
// valid/ready request plus one response on the memory bus. The CPU is stalled
// until the response arrives, or until the response timeout fires and a bus
// error is flagged.
module data_bus_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_wr,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        bus_err,
    output logic        bus_err_sticky
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(TIMEOUT);

    state_e                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            rd_q, rd_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   we_q, we_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   sticky_q, sticky_d;

    // Byte offset is dropped: the bus is word addressed, strobes select bytes.
    logic unused_addr;
    assign unused_addr = ^cpu_addr[1:0];

    // Next-state logic for the request/response sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        we_d     = we_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_ren || cpu_wen) begin
                    // A simultaneous load and store is treated as a store.
                    addr_d  = {cpu_addr[31:2], 2'b00};
                    we_d    = cpu_wen;
                    wdata_d = cpu_wr;
                    wstrb_d = cpu_wen ? cpu_wstrb : 4'b0000;
                    valid_d = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                // No timeout here: the slave may back-pressure indefinitely.
                if (mem_req_ready) begin
                    valid_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the final counted cycle still beats the timeout.
                if (mem_rsp_valid) begin
                    if (!we_q) begin
                        rd_d = mem_rsp_rdata;
                    end
                    state_d = StDone;
                end else if (cnt_d == TimeoutVal) begin
                    if (!we_q) begin
                        rd_d = ERR_DATA;
                    end
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            we_q     <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            we_q     <= we_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    // Stall is combinational so the CPU freezes in the very cycle it issues.
    assign cpu_stall = ((state_q == StIdle) && (cpu_ren || cpu_wen))
                     || (state_q == StReq) || (state_q == StWait);

    assign cpu_rd         = rd_q;
    assign mem_req_valid  = valid_q;
    assign mem_req_we     = we_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wstrb  = wstrb_q;
    assign bus_err        = err_q;
    assign bus_err_sticky = sticky_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench for data_bus_bridge: expected requests and retirements are
// queued when an access is driven and compared when the bridge produces them.
module tb_data_bus_bridge;

    localparam int unsigned Timeout = 255;
    localparam logic [31:0] ErrData = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [31:0] cpu_wr = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        bus_err;
    logic        bus_err_sticky;

    data_bus_bridge #(
        .TIMEOUT   (Timeout),
        .TIMEOUT_W (8),
        .ERR_DATA  (ErrData)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_ren        (cpu_ren),
        .cpu_wen        (cpu_wen),
        .cpu_wr         (cpu_wr),
        .cpu_wstrb      (cpu_wstrb),
        .cpu_rd         (cpu_rd),
        .cpu_stall      (cpu_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_rdata  (mem_rsp_rdata),
        .bus_err        (bus_err),
        .bus_err_sticky (bus_err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        sticky;
        int          stall;
    } ret_t;

    req_t req_q[$];
    ret_t ret_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [31:0] model_rd     = '0;
    logic        model_sticky = 1'b0;

    // Slave model state
    int          slv_phase = 0;
    int          slv_rdy_cnt = 0;
    int          slv_rsp_cnt = 0;
    int          cfg_rdy = 0;
    int          cfg_rsp = 0;
    logic [31:0] cfg_rdata = '0;

    int   stall_cnt = 0;
    ret_t mon_r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One slave step, called just after each rising edge.
    task automatic slave_step();
        mem_rsp_valid = 1'b0;
        if (mem_req_ready) begin
            mem_req_ready = 1'b0;
            slv_phase     = 2;
            slv_rsp_cnt   = 0;
        end else if (mem_req_valid && slv_phase == 0) begin
            if (slv_rdy_cnt == cfg_rdy) mem_req_ready = 1'b1;
            else slv_rdy_cnt++;
        end
        if (slv_phase == 2) begin
            if (cfg_rsp >= 0 && slv_rsp_cnt == cfg_rsp) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = cfg_rdata;
                slv_phase     = 0;
            end else begin
                slv_rsp_cnt++;
            end
        end
    endtask

    // Drive one CPU access (entered just after a rising edge); rsp < 0 means never.
    task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wr, input logic [3:0] strb, input int rdy,
                          input int rsp, input logic [31:0] rdata, input bit stray);
        req_t q;
        ret_t r;
        int   guard;
        q.addr  = {addr[31:2], 2'b00};
        q.we    = wen;
        q.wdata = wr;
        q.wstrb = wen ? strb : 4'b0000;
        req_q.push_back(q);
        r.err = (rsp < 0);
        if (!wen) model_rd = r.err ? ErrData : rdata;
        model_sticky = model_sticky | r.err;
        r.rd     = model_rd;
        r.sticky = model_sticky;
        r.stall  = r.err ? (2 + Timeout) : (3 + rdy + rsp);
        ret_q.push_back(r);

        cpu_addr    = addr;
        cpu_ren     = ren;
        cpu_wen     = wen;
        cpu_wr      = wr;
        cpu_wstrb   = strb;
        cfg_rdy     = rdy;
        cfg_rsp     = rsp;
        cfg_rdata   = rdata;
        slv_phase   = 0;
        slv_rdy_cnt = 0;
        slave_step();
        // Response while the bridge is still idle must be ignored.
        if (stray) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h0BAD0BAD;
        end
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            slave_step();
            guard++;
        end while (cpu_stall && guard < 1000);
        check_eq("stall_bound", 32'(guard >= 1000), 32'd0);
        // Retire cycle is checked by the monitor; release inputs after it.
        @(posedge clk);
        #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        slave_step();
    endtask

    // Monitor: request fields held through REQ, retirement results, error pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
        end else begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    check_eq("req_unexpected", {31'b0, mem_req_valid}, 32'd0);
                end else begin
                    check_eq("req_addr", mem_req_addr, req_q[0].addr);
                    check_eq("req_we", {31'b0, mem_req_we}, {31'b0, req_q[0].we});
                    check_eq("req_wdata", mem_req_wdata, req_q[0].wdata);
                    check_eq("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, req_q[0].wstrb});
                    if (mem_req_ready) void'(req_q.pop_front());
                end
            end
            if ((cpu_ren || cpu_wen) && cpu_stall) begin
                stall_cnt++;
                check_eq("bus_err_busy", {31'b0, bus_err}, 32'd0);
            end else if (cpu_ren || cpu_wen) begin
                if (ret_q.size() == 0) begin
                    check_eq("ret_queue", 32'(ret_q.size()), 32'd1);
                end else begin
                    mon_r = ret_q.pop_front();
                    check_eq("cpu_rd", cpu_rd, mon_r.rd);
                    check_eq("bus_err", {31'b0, bus_err}, {31'b0, mon_r.err});
                    check_eq("bus_err_sticky", {31'b0, bus_err_sticky}, {31'b0, mon_r.sticky});
                    check_eq("stall_cycles", 32'(stall_cnt), 32'(mon_r.stall));
                end
                stall_cnt = 0;
            end else begin
                check_eq("bus_err_idle", {31'b0, bus_err}, 32'd0);
            end
        end
    end

    initial begin
        logic rr, ww;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cpu_rd", cpu_rd, 32'd0);
        check_eq("rst_valid", {31'b0, mem_req_valid}, 32'd0);
        check_eq("rst_addr", mem_req_addr, 32'd0);
        check_eq("rst_sticky", {31'b0, bus_err_sticky}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_stall", {31'b0, cpu_stall}, 32'd0);

        // Minimum-latency load, then store with delayed ready.
        access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 32'hCAFEF00D, 1'b0);
        access(1'b0, 1'b1, 32'h0000_2007, 32'h0000_00AB, 4'b1000, 4, 0, 32'h0, 1'b0);
        // Dead slave, then a response landing in the last counted cycle.
        access(1'b1, 1'b0, 32'h0000_1010, 32'h0, 4'h0, 0, -1, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_1020, 32'h0, 4'h0, 0, Timeout - 1, 32'h1234_5678, 1'b0);
        // Back-to-back loads with a stray response in the intervening idle cycle.
        access(1'b1, 1'b0, 32'h0000_1100, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 1'b0);
        access(1'b1, 1'b0, 32'h0000_1104, 32'h0, 4'h0, 0, 0, 32'h2222_2222, 1'b1);
        // Load and store together behave as a store.
        access(1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1111, 1, 2, 32'h5A5A_5A5A, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ww = 1'($urandom_range(0, 1));
            rr = !ww || 1'($urandom_range(0, 1));
            access(rr, ww, $urandom(), $urandom(), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom(), 1'b0);
        end

        // Reset while waiting for a response that never comes.
        req_q.push_back('{addr: 32'h0000_4008, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        cpu_addr = 32'h0000_4008;
        cpu_ren  = 1'b1;
        cpu_wr   = 32'h0;
        cfg_rdy  = 0;
        cfg_rsp  = -1;
        slv_phase   = 0;
        slv_rdy_cnt = 0;
        slave_step();
        repeat (5) begin
            @(posedge clk);
            #1;
            slave_step();
        end
        check_eq("pre_rst_stall", {31'b0, cpu_stall}, 32'd1);
        cpu_ren = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_rd     = '0;
        model_sticky = 1'b0;
        check_eq("arst_valid", {31'b0, mem_req_valid}, 32'd0);
        check_eq("arst_cpu_rd", cpu_rd, 32'd0);
        check_eq("arst_sticky", {31'b0, bus_err_sticky}, 32'd0);
        check_eq("arst_stall", {31'b0, cpu_stall}, 32'd0);
        check_eq("arst_wstrb", {28'b0, mem_req_wstrb}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slv_phase = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'hFEED_0000 + 32'(i);
            @(posedge clk);
            #1;
            check_eq("late_rsp_cpu_rd", cpu_rd, 32'd0);
            check_eq("late_rsp_stall", {31'b0, cpu_stall}, 32'd0);
            check_eq("late_rsp_valid", {31'b0, mem_req_valid}, 32'd0);
        end
        mem_rsp_valid = 1'b0;

        // Recovery after reset.
        access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 2, 1, 32'h5555_AAAA, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("req_q_empty", 32'(req_q.size()), 32'd0);
        check_eq("ret_q_empty", 32'(ret_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        check_eq("global_timeout", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
